// File: rtl/product_bcd_display_pkg.sv
// Shared definitions for the product display path: FSM states, active-high
// 7-segment codes ({g,f,e,d,c,b,a}) and the double-dabble nibble adjust.
package product_bcd_display_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_e;

    localparam int BCD_W = 12;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Every BCD nibble of 5 or more gets +3 ahead of the next left shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int unsigned n = 0; n < 3; n++) begin
            if (r[4*n +: 4] >= 4'd5) begin
                r[4*n +: 4] = r[4*n +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/product_bcd_display_if.sv
// Bus between the multiplier (master) and the BCD/FND display stage (slave).
interface product_bcd_display_if #(
    parameter int WIDTH = 8
);
    logic             valid_in;
    logic [WIDTH-1:0] product_in;
    logic             busy;
    logic             done;
    logic [3:0]       bcd_hundreds;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic [6:0]       fnd_01;
    logic [6:0]       fnd_02;
    logic [6:0]       fnd_03;

    modport master (
        output valid_in, product_in,
        input  busy, done, bcd_hundreds, bcd_tens, bcd_ones,
        input  fnd_01, fnd_02, fnd_03
    );

    modport slave (
        input  valid_in, product_in,
        output busy, done, bcd_hundreds, bcd_tens, bcd_ones,
        output fnd_01, fnd_02, fnd_03
    );
endinterface

// File: rtl/product_bcd_display_fnd_decoder.sv
// Combinational BCD digit to active-high 7-segment decoder; codes 10..15 blank.
module fnd_decoder
    import product_bcd_display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/product_bcd_display.sv
// Captures a product, converts it to three BCD digits by sequential
// double-dabble (one step per clock) and drives three 7-segment displays.
module product_bcd_display
    import product_bcd_display_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    product_bcd_display_if.slave  bus
);

    localparam logic [3:0] LAST_STEP = 4'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   scr_q,   scr_d;
    logic [3:0]         cnt_q,   cnt_d;
    logic               pend_q,  pend_d;
    logic [WIDTH-1:0]   pval_q,  pval_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic               done_q,  done_d;
    logic [BCD_W+WIDTH-1:0] step_w;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pval_q  <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        step_w  = {dd_adjust(scr_q), shift_q} << 1;

        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    shift_d = bus.product_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                {scr_d, shift_d} = step_w;
                cnt_d            = cnt_q + 4'd1;
                if (bus.valid_in) begin
                    pend_d = 1'b1;
                    pval_d = bus.product_in;
                end
                // A request arriving on the final step restarts directly, bypassing the slot.
                if (cnt_q == LAST_STEP) begin
                    bcd_d  = step_w[BCD_W+WIDTH-1:WIDTH];
                    done_d = 1'b1;
                    if (bus.valid_in || pend_q) begin
                        shift_d = bus.valid_in ? bus.product_in : pval_q;
                        scr_d   = '0;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [3:0] hund, tens, ones;
    logic       blank_h, blank_t;
    logic [6:0] seg_h, seg_t, seg_o;

    assign hund    = bcd_q[11:8];
    assign tens    = bcd_q[7:4];
    assign ones    = bcd_q[3:0];
    assign blank_h = (BLANK_LZ != 0) && (hund == 4'd0);
    assign blank_t = blank_h && (tens == 4'd0);

    fnd_decoder u_dec_ones (.digit_i(ones), .blank_i(1'b0),    .seg_o(seg_o));
    fnd_decoder u_dec_tens (.digit_i(tens), .blank_i(blank_t), .seg_o(seg_t));
    fnd_decoder u_dec_hund (.digit_i(hund), .blank_i(blank_h), .seg_o(seg_h));

    assign bus.busy         = (state_q == ST_CONV);
    assign bus.done         = done_q;
    assign bus.bcd_hundreds = hund;
    assign bus.bcd_tens     = tens;
    assign bus.bcd_ones     = ones;
    assign bus.fnd_01       = (SEG_ACTIVE_LOW != 0) ? ~seg_o : seg_o;
    assign bus.fnd_02       = (SEG_ACTIVE_LOW != 0) ? ~seg_t : seg_t;
    assign bus.fnd_03       = (SEG_ACTIVE_LOW != 0) ? ~seg_h : seg_h;

endmodule

// File: tb/tb_product_bcd_display.sv
// Self-checking bench for product_bcd_display (WIDTH=8, active-low, blanking on).
module tb_product_bcd_display;

    localparam int W = 8;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    product_bcd_display_if #(.WIDTH(W)) bus ();

    product_bcd_display #(
        .WIDTH(W),
        .SEG_ACTIVE_LOW(1),
        .BLANK_LZ(1)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int prev   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Active-low segment patterns for digits 0..9, blank = all off.
    function automatic logic [6:0] exp_fnd(input int d, input bit blank);
        if (blank) return 7'h7F;
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check_value(input string tag, input int v);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        chk({tag, ".hund"}, 32'(bus.bcd_hundreds), 32'(h));
        chk({tag, ".tens"}, 32'(bus.bcd_tens), 32'(t));
        chk({tag, ".ones"}, 32'(bus.bcd_ones), 32'(o));
        chk({tag, ".fnd01"}, 32'(bus.fnd_01), 32'(exp_fnd(o, 1'b0)));
        chk({tag, ".fnd02"}, 32'(bus.fnd_02), 32'(exp_fnd(t, (h == 0) && (t == 0))));
        chk({tag, ".fnd03"}, 32'(bus.fnd_03), 32'(exp_fnd(h, h == 0)));
    endtask

    task automatic do_convert(input string tag, input int v);
        int lat, ndone;
        @(negedge clk);
        bus.valid_in   = 1'b1;
        bus.product_in = 8'(v);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        lat   = 0;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
            if (k == 4) check_value({tag, ".hold"}, prev);
            if (bus.done === 1'b1) begin
                ndone++;
                if (lat == 0) begin
                    lat = k;
                    check_value(tag, v);
                end
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(W + 1));
        chk({tag, ".ndone"}, 32'(ndone), 32'd1);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
        prev = v;
    endtask

    // v0 at E0, v1 before edge t1, optional v2 before edge t2; vfin is the value expected second.
    task automatic b2b(input string tag, input int v0, input int t1, input int v1,
                       input int t2, input int v2, input int vfin);
        int ndone, d1, d2, busy_bad, cyc;
        @(negedge clk);
        bus.valid_in   = 1'b1;
        bus.product_in = 8'(v0);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        ndone = 0; d1 = -1; d2 = -1; busy_bad = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            cyc = i - 1;
            if (bus.busy !== ((cyc <= 15) ? 1'b1 : 1'b0)) busy_bad++;
            if (bus.done === 1'b1) begin
                ndone++;
                if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc;
                if (cyc == 8)  check_value({tag, ".first"}, v0);
                if (cyc == 16) check_value({tag, ".second"}, vfin);
            end
            if (i == t1) begin
                bus.valid_in = 1'b1; bus.product_in = 8'(v1);
            end else if (t2 != 0 && i == t2) begin
                bus.valid_in = 1'b1; bus.product_in = 8'(v2);
            end else begin
                bus.valid_in = 1'b0;
            end
        end
        bus.valid_in = 1'b0;
        chk({tag, ".ndone"}, 32'(ndone), 32'd2);
        chk({tag, ".done1_cyc"}, 32'(d1), 32'd8);
        chk({tag, ".done2_cyc"}, 32'(d2), 32'd16);
        chk({tag, ".busy_profile"}, 32'(busy_bad), 32'd0);
        prev = vfin;
    endtask

    initial begin
        int ndone;
        n_rst          = 1'b0;
        bus.valid_in   = 1'b0;
        bus.product_in = '0;
        #2;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        check_value("reset", 0);
        @(negedge clk);
        n_rst = 1'b1;

        do_convert("p45", 45);
        do_convert("p225", 225);
        do_convert("p0", 0);

        b2b("b2b", 28, 3, 16, 5, 81, 81);
        b2b("final_step", 200, 8, 37, 0, 0, 37);

        do_convert("pre_rst", 225);
        @(negedge clk);
        bus.valid_in   = 1'b1;
        bus.product_in = 8'd99;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.done", 32'(bus.done), 32'd0);
        check_value("midrst", 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("midrst.no_done", 32'(ndone), 32'd0);
        check_value("midrst.held", 0);
        prev = 0;
        do_convert("after_rst", 9);

        for (int n = 0; n < 24; n++) begin
            do_convert("rand", int'($urandom_range(0, 255)));
        end
        for (int v = 0; v < 256; v++) begin
            do_convert("sweep", v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
